// File: rtl/knight_trail_pkg.sv
// Shared sizing constants and types for the knight flasher afterglow stage.
package knight_pkg;
    localparam int LED_N         = 8;
    localparam int BRIGHT_W      = 4;
    localparam int BRIGHT_MAX    = (1 << BRIGHT_W) - 1;
    localparam int DEFAULT_DECAY = 4;

    typedef logic [BRIGHT_W-1:0] level_t;
endpackage

// File: rtl/knight_trail_if.sv
// Scanner-to-trail link: step/pos come from the scanner, led/period/ovf go out.
interface knight_trail_if
    import knight_pkg::*;
#(
    parameter int N = LED_N
);
    logic         step;
    logic [N-1:0] pos;
    logic [N-1:0] led;
    logic         period;
    logic         ovf;

    // scanner side
    modport master (output step, pos, input led, period, ovf);
    // trail stage side
    modport slave  (input step, pos, output led, period, ovf);
endinterface

// File: rtl/knight_trail_ch.sv
// One LED channel: brightness level register plus registered PWM comparator.
module knight_trail_ch
    import knight_pkg::*;
#(
    parameter int BW    = BRIGHT_W,
    parameter int DECAY = DEFAULT_DECAY
)(
    input  logic          ck,
    input  logic          res,
    input  logic          upd_i,   // period-boundary update enable, shared by all channels
    input  logic          src_i,   // this channel is lit by the applied position
    input  logic [BW-1:0] cnt_i,   // shared PWM counter
    output logic          led_o
);
    localparam logic [BW-1:0] LVL_MAX = '1;
    // one extra bit so the compare below never wraps
    localparam logic [BW:0]   DEC     = (BW+1)'(DECAY);

    logic [BW-1:0] level_q, level_d, decayed;
    logic          led_q, led_d;

    // saturating decay: anything at or below DECAY drops straight to 0
    always_comb begin
        decayed = '0;
        if ({1'b0, level_q} > DEC) decayed = level_q - DEC[BW-1:0];
    end

    // level: load full on lit, decay otherwise, hold between updates
    always_comb begin
        level_d = level_q;
        if (upd_i) level_d = src_i ? LVL_MAX : decayed;
        led_d   = (level_q > cnt_i);
    end

    // level and PWM output registers
    always_ff @(posedge ck) begin
        if (res) begin
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;
endmodule

// File: rtl/knight_trail.sv
// Afterglow PWM stage: levels change only at PWM period boundaries.
module knight_trail
    import knight_pkg::*;
#(
    parameter int N     = LED_N,
    parameter int BW    = BRIGHT_W,
    parameter int DECAY = DEFAULT_DECAY
)(
    input  logic          ck,
    input  logic          res,
    knight_trail_if.slave bus
);
    localparam int            MAX      = (1 << BW) - 1;
    localparam logic [BW-1:0] CNT_LAST = BW'(MAX - 1);

    logic [BW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  pos_q, pos_d;
    logic          pending_q, pending_d;
    logic          ovf_q, ovf_d;
    logic          period_q;
    logic          wrap, upd;
    logic [N-1:0]  src, led_w;

    assign wrap = (cnt_q == CNT_LAST);
    // a step landing on the wrap cycle is applied at once and bypasses pos_q
    assign upd  = wrap & (pending_q | bus.step);
    assign src  = bus.step ? bus.pos : pos_q;

    // counter, step capture and overflow tracking
    always_comb begin
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        pos_d     = bus.step ? bus.pos : pos_q;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        if (wrap) begin
            pending_d = 1'b0;
        end else if (bus.step) begin
            pending_d = 1'b1;
            if (pending_q) ovf_d = 1'b1;
        end
    end

    // control state registers
    always_ff @(posedge ck) begin
        if (res) begin
            cnt_q     <= '0;
            pos_q     <= '0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
            period_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            period_q  <= wrap;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        knight_trail_ch #(
            .BW    (BW),
            .DECAY (DECAY)
        ) u_ch (
            .ck    (ck),
            .res   (res),
            .upd_i (upd),
            .src_i (src[i]),
            .cnt_i (cnt_q),
            .led_o (led_w[i])
        );
    end

    assign bus.led    = led_w;
    assign bus.period = period_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_knight_trail.sv
// Directed bench: each table row is one 15-cycle window (cnt 1..14 then 0),
// steps driven inside it, led high-counts per channel compared to the level
// expected to be live in that PWM period.
module tb_knight_trail;
    import knight_pkg::*;

    logic ck  = 1'b0;
    logic res = 1'b1;

    knight_trail_if #(.N(8)) bus ();

    knight_trail #(.N(8), .BW(4), .DECAY(4)) dut (
        .ck  (ck),
        .res (res),
        .bus (bus)
    );

    always #5 ck = ~ck;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        s1;
        logic [7:0]  p1;
        int          c1;
        logic        s2;
        logic [7:0]  p2;
        int          c2;
        logic [31:0] hc;   // expected high cycles, nibble i = channel i
        logic        ovf;
    } row_t;

    row_t rows[16];

    function automatic row_t mk(input logic s1, input logic [7:0] p1, input int c1,
                                input logic s2, input logic [7:0] p2, input int c2,
                                input logic [31:0] hc, input logic ovf);
        row_t r;
        r.s1 = s1; r.p1 = p1; r.c1 = c1;
        r.s2 = s2; r.p2 = p2; r.c2 = c2;
        r.hc = hc; r.ovf = ovf;
        return r;
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // entered in the cnt=1 cycle, leaves in the next cnt=1 cycle
    task automatic run_row(input int w, input row_t r);
        int          hc[8];
        logic [14:0] pm;
        logic        ovf_s;
        pm    = '0;
        ovf_s = 1'b0;
        for (int i = 0; i < 8; i++) hc[i] = 0;
        for (int j = 0; j < 15; j++) begin
            int c;
            c = (j + 1) % 15;
            bus.step = 1'b0;
            bus.pos  = '0;
            if (r.s1 && c == r.c1) begin bus.step = 1'b1; bus.pos = r.p1; end
            if (r.s2 && c == r.c2) begin bus.step = 1'b1; bus.pos = r.p2; end
            for (int i = 0; i < 8; i++) if (bus.led[i]) hc[i]++;
            pm[j] = bus.period;
            if (j == 14) ovf_s = bus.ovf;
            tick();
        end
        bus.step = 1'b0;
        bus.pos  = '0;
        for (int i = 0; i < 8; i++)
            chk($sformatf("w%0d ch%0d high", w, i), 32'(hc[i]), 32'(r.hc[i*4 +: 4]));
        chk($sformatf("w%0d period", w), 32'(pm), 32'h4000);
        chk($sformatf("w%0d ovf", w), 32'(ovf_s), 32'(r.ovf));
    endtask

    initial begin
        bus.step = 1'b0;
        bus.pos  = '0;

        rows[0]  = mk(0, 8'h00, 0,  0, 8'h00, 0, 32'h0000_0000, 0);
        rows[1]  = mk(0, 8'h00, 0,  0, 8'h00, 0, 32'h0000_0000, 0);
        rows[2]  = mk(0, 8'h00, 0,  0, 8'h00, 0, 32'h0000_0000, 0);
        rows[3]  = mk(1, 8'h01, 3,  0, 8'h00, 0, 32'h0000_0000, 0);
        rows[4]  = mk(1, 8'h02, 5,  0, 8'h00, 0, 32'h0000_000F, 0);
        rows[5]  = mk(1, 8'h04, 7,  0, 8'h00, 0, 32'h0000_00FB, 0);
        rows[6]  = mk(0, 8'h00, 0,  0, 8'h00, 0, 32'h0000_0FB7, 0);
        rows[7]  = mk(1, 8'h80, 14, 0, 8'h00, 0, 32'h0000_0FB7, 0);  // step on wrap
        rows[8]  = mk(0, 8'h00, 0,  0, 8'h00, 0, 32'hF000_0B73, 0);
        rows[9]  = mk(0, 8'h00, 0,  0, 8'h00, 0, 32'hF000_0B73, 0);  // no extra decay
        rows[10] = mk(1, 8'h01, 2,  1, 8'h10, 9, 32'hF000_0B73, 1);  // two steps
        rows[11] = mk(1, 8'h00, 4,  0, 8'h00, 0, 32'hB00F_0730, 1);  // pos=0
        rows[12] = mk(1, 8'h81, 1,  0, 8'h00, 0, 32'h700B_0300, 1);  // multi-bit pos
        rows[13] = mk(0, 8'h00, 0,  0, 8'h00, 0, 32'hF007_000F, 1);
        rows[14] = mk(0, 8'h00, 0,  0, 8'h00, 0, 32'h0000_0000, 0);
        rows[15] = mk(0, 8'h00, 0,  0, 8'h00, 0, 32'h0000_0000, 0);

        repeat (3) tick();
        chk("reset led", 32'(bus.led), 32'h0);
        chk("reset period", 32'(bus.period), 32'h0);
        chk("reset ovf", 32'(bus.ovf), 32'h0);
        res = 1'b0;
        tick();

        for (int w = 0; w < 14; w++) run_row(w, rows[w]);

        // reset mid-period with a step pending: must drop the step
        bus.step = 1'b1;
        bus.pos  = 8'h02;
        tick();
        bus.step = 1'b0;
        bus.pos  = '0;
        tick();
        tick();
        chk("pre-reset led0 lit", 32'(bus.led[0]), 32'h1);
        res = 1'b1;
        tick();
        chk("midreset led", 32'(bus.led), 32'h0);
        chk("midreset period", 32'(bus.period), 32'h0);
        chk("midreset ovf", 32'(bus.ovf), 32'h0);
        res = 1'b0;
        tick();

        for (int w = 14; w < 16; w++) run_row(w, rows[w]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
